sprite_renderer: RTL and testbench

//  Pixel-side consumer of the ball position/size bus (BallX, BallY, BallS) that the motion block updates once per frame.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_renderer_rom.sv | 27 ++
 rtl/sprite_renderer.sv | 120 ++++++++++++
 tb/tb_sprite_renderer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite renderer.
// Optional feature macro: SPRITE_TRANSPARENCY_EN (palette index 0 becomes transparent).
package sprite_pkg;

  localparam int SPR_DIM_DEF = 16;
  localparam int IDX_W_DEF   = 4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Colour lookup for each bitmap index
  localparam logic [23:0] PALETTE [2**IDX_W_DEF] = '{
    24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h808080,
    24'hC00000, 24'h00C000, 24'h0000C0, 24'hC0C000,
    24'h00C0C0, 24'hC000C0, 24'h404040, 24'hFF8000
  };

  // Limit the requested half-size so the box never exceeds the bitmap
  function automatic logic [9:0] clamp_size(input logic [9:0] s, input logic [9:0] lim);
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/sprite_renderer_rom.sv
// Sprite bitmap ROM: SPR_DIM x SPR_DIM entries of palette indices, one-cycle
// registered read gated by the read enable. The bitmap is a fixed pattern:
// index = row XOR column (diagonals carry index 0).
module sprite_rom #(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [IDX_W-1:0]  o_idx
);

  localparam int HALF = ADDR_W / 2;

  logic [IDX_W-1:0] r_idx;

  // Registered read; the held value stays put while the pixel strobe is low
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_idx <= IDX_W'(i_addr[ADDR_W-1:HALF] ^ i_addr[HALF-1:0]);
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/sprite_renderer.sv
// Sprite renderer: latches ball position at frame start, tests each pixel
// against the sprite box, fetches the bitmap index and drives RGB.
// Two pixel_en strobes of latency from DrawX/DrawY/blank to RGB.
// Optional feature macro: SPRITE_TRANSPARENCY_EN (index 0 shows background).
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int          SPR_DIM = SPR_DIM_DEF,
  parameter int          IDX_W   = IDX_W_DEF,
  parameter logic [23:0] BG_RGB  = 24'h3F007F,
  parameter int          X_INIT  = 320,
  parameter int          Y_INIT  = 240,
  parameter int          S_INIT  = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pixel_en,
  input  logic       frame_start,
  input  logic       blank,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       sprite_on
);

  localparam int LOG    = $clog2(SPR_DIM);
  localparam int ADDR_W = 2 * LOG;

  logic [9:0]        r_sh_x, r_sh_y, r_sh_s;
  logic signed [10:0] w_dx, w_dy, w_two_s;
  logic              w_in_box;
  logic [ADDR_W-1:0] w_addr;
  logic              r_s1_valid, r_s1_in_box, r_s1_blank;
  logic [IDX_W-1:0]  w_idx;
  rgb_t              w_pal;
  logic              w_opaque;
  rgb_t              r_rgb;
  logic              r_on;

  // Shadow copy of the ball bus, refreshed only at frame start to avoid tearing
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sh_x <= 10'(X_INIT);
      r_sh_y <= 10'(Y_INIT);
      r_sh_s <= 10'(S_INIT);
    end else if (frame_start) begin
      r_sh_x <= BallX;
      r_sh_y <= BallY;
      r_sh_s <= clamp_size(BallS, 10'(SPR_DIM / 2));
    end
  end

  // Box test in 11-bit signed space so a box crossing column/row 0 clips instead of wrapping
  assign w_dx     = $signed({1'b0, DrawX}) - $signed({1'b0, r_sh_x}) + $signed({1'b0, r_sh_s});
  assign w_dy     = $signed({1'b0, DrawY}) - $signed({1'b0, r_sh_y}) + $signed({1'b0, r_sh_s});
  assign w_two_s  = $signed({r_sh_s, 1'b0});
  assign w_in_box = !w_dx[10] && (w_dx < w_two_s) && !w_dy[10] && (w_dy < w_two_s);
  assign w_addr   = {w_dy[LOG-1:0], w_dx[LOG-1:0]};

  // Stage 1: pixel flags; the ROM reads the same address in parallel
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_in_box <= 1'b0;
      r_s1_blank  <= 1'b0;
    end else if (pixel_en) begin
      r_s1_valid  <= 1'b1;
      r_s1_in_box <= w_in_box;
      r_s1_blank  <= blank;
    end
  end

  sprite_rom #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_rom (
    .i_clk  (Clk),
    .i_re   (pixel_en),
    .i_addr (w_addr),
    .o_idx  (w_idx)
  );

  assign w_pal = rgb_t'(PALETTE[w_idx]);

`ifdef SPRITE_TRANSPARENCY_EN
  assign w_opaque = (w_idx != '0);
`else
  assign w_opaque = 1'b1;
`endif

  // Output stage: blank wins, then opaque sprite pixel, else background
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rgb <= '0;
      r_on  <= 1'b0;
    end else if (pixel_en) begin
      if (!r_s1_valid || r_s1_blank) begin
        r_rgb <= '0;
        r_on  <= 1'b0;
      end else if (r_s1_in_box && w_opaque) begin
        r_rgb <= w_pal;
        r_on  <= 1'b1;
      end else begin
        r_rgb <= rgb_t'(BG_RGB);
        r_on  <= 1'b0;
      end
    end
  end

  assign Red       = r_rgb.r;
  assign Green     = r_rgb.g;
  assign Blue      = r_rgb.b;
  assign sprite_on = r_on;

endmodule

// File: tb/tb_sprite_renderer.sv
// Testbench for sprite_renderer: directed scenarios followed by randomized
// pixel streams, checked through an expected-response queue.
module tb_sprite_renderer;

  localparam logic [23:0] BG = 24'h3F007F;
  localparam logic [23:0] PAL [16] = '{
    24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h808080,
    24'hC00000, 24'h00C000, 24'h0000C0, 24'hC0C000,
    24'h00C0C0, 24'hC000C0, 24'h404040, 24'hFF8000
  };

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       pixel_en = 1'b0, frame_start = 1'b0, blank = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, BallX = '0, BallY = '0, BallS = '0;
  logic [7:0] Red, Green, Blue;
  logic       sprite_on;

  always #5 Clk = ~Clk;

  sprite_renderer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pixel_en    (pixel_en),
    .frame_start (frame_start),
    .blank       (blank),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .BallX       (BallX),
    .BallY       (BallY),
    .BallS       (BallS),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .sprite_on   (sprite_on)
  );

  // ---------------- reference model ----------------
  int          sh_x, sh_y, sh_s;
  logic [24:0] pend;
  bit          pend_valid;
  logic [24:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  // Expected {sprite_on, RGB} for one pixel, from geometry alone
  function automatic logic [24:0] model(input int x, input int y, input bit bl);
    int col, row, idx;
    if (bl) return 25'd0;
    if (sh_s == 0 || x < sh_x - sh_s || x >= sh_x + sh_s ||
        y < sh_y - sh_s || y >= sh_y + sh_s)
      return {1'b0, BG};
    col = x - (sh_x - sh_s);
    row = y - (sh_y - sh_s);
    idx = row ^ col;
`ifdef SPRITE_TRANSPARENCY_EN
    if (idx == 0) return {1'b0, BG};
`endif
    return {1'b1, PAL[idx]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    sh_x = 320; sh_y = 240; sh_s = 8;
    pend_valid = 1'b0;
    pend = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; pixel_en = 1'b0; frame_start = 1'b0;
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic set_ball(input int x, input int y, input int s);
    BallX = 10'(x); BallY = 10'(y); BallS = 10'(s);
  endtask

  // One clock: apply pixel inputs and update the model
  task automatic step(input bit pe, input bit fs, input bit bl, input int x, input int y);
    logic [24:0] resp;
    @(negedge Clk);
    pixel_en = pe; frame_start = fs; blank = bl;
    DrawX = 10'(x); DrawY = 10'(y);
    if (pe) begin
      resp = model(x, y, bl);
      exp_q.push_back(pend_valid ? pend : 25'd0);
      pend = resp;
      pend_valid = 1'b1;
    end
    if (fs) begin
      sh_x = int'(BallX);
      sh_y = int'(BallY);
      sh_s = (int'(BallS) > 8) ? 8 : int'(BallS);
    end
  endtask

  task automatic pix(input int x, input int y);
    step(1'b1, 1'b0, 1'b0, x, y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got on=%0b rgb=%06h, expected on=%0b rgb=%06h",
               name, act[24], act[23:0], exp[24], exp[23:0]);
    end
  endtask

  logic [24:0] held = '0;

  always @(posedge Clk) begin
    logic r, p;
    logic [24:0] e;
    r = Reset;
    p = pixel_en;
    #2;
    if (r) begin
      check("reset", {sprite_on, Red, Green, Blue}, 25'd0);
      held = 25'd0;
    end else if (p) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL underflow: DUT strobe with no expected entry");
      end else begin
        e = exp_q.pop_front();
        check("pixel", {sprite_on, Red, Green, Blue}, e);
        held = e;
      end
    end else begin
      check("hold", {sprite_on, Red, Green, Blue}, held);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int x, y;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Box after reset is 312..327 x 232..247
    pix(312, 232);
    pix(327, 247);
    pix(328, 247);
    pix(320, 235);
    pix(0, 0);
    // Left-edge clipping
    set_ball(4, 100, 8);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    pix(0, 92);
    pix(11, 107);
    pix(12, 107);
    pix(1023, 92);
    // Mid-frame ball change is ignored until frame_start
    set_ball(500, 300, 8);
    pix(5, 95);
    step(1'b1, 1'b1, 1'b0, 6, 96);
    pix(6, 96);
    pix(495, 296);
    // Blank inside box, frozen outputs, size clamp
    step(1'b1, 1'b0, 1'b1, 500, 300);
    pix(500, 300);
    idle(5);
    set_ball(300, 200, 20);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    pix(292, 192);
    pix(291, 192);
    pix(307, 207);
    pix(308, 207);
    // Empty box
    set_ball(100, 100, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    pix(100, 100);
    pix(99, 99);
    // Mid-frame reset
    pix(100, 100);
    do_reset();
    pix(312, 232);
    pix(320, 240);
    pix(330, 240);

    // Randomized streams around the current sprite
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_ball($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 20));
        step(1'b0, 1'b1, 1'b0, 0, 0);
      end
      if (i == 300) do_reset();
      x = sh_x + $urandom_range(0, 24) - 12;
      y = sh_y + $urandom_range(0, 24) - 12;
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 9) == 0, x, y);
    end

    idle(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
